// File: rtl/ccff_chain_loader_pkg.sv
// rtl/ccff_chain_loader_pkg.sv - shared states and CRC-16-CCITT helpers for the ccff chain loader
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One serial MSB-first step: feedback is the outgoing MSB xor the incoming bit.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    crc16_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// rtl/ccff_crc16_serial.sv - bit-serial CRC-16-CCITT accumulator
module ccff_crc16_serial
  import ccff_chain_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_next(crc, din);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises config words MSB-first into the ccff chain head
// Optional tail recirculation CRC check: CCFF_CHAIN_LOADER_TAIL_CHECK_EN
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;
  localparam int BL_W      = $clog2(WORD_W + 1);
  localparam int WC_W      = $clog2(N_WORDS + 1);

`ifdef CCFF_CHAIN_LOADER_TAIL_CHECK_EN
  localparam bit TAIL_CHECK = 1'b1;
`else
  localparam bit TAIL_CHECK = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] word_buf;
  logic [BL_W-1:0]   bits_left;
  logic [WC_W-1:0]   words_acc;
  logic              head_q;
  logic              verr_q;
  logic              restart;
  logic              shift_load;
  logic              take;
  logic              last_bit;

  assign restart    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign shift_load = (state_q == ST_LOAD) && (bits_left != '0);
  assign last_bit   = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  // Refill while the last buffered bit leaves so consecutive words shift without a bubble.
  assign cfg_ready  = (state_q == ST_LOAD)
                    && ((bits_left == '0) || (bits_left == BL_W'(1) && shift_load))
                    && (words_acc < WC_W'(N_WORDS));
  assign take       = cfg_valid && cfg_ready;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
  assign done       = (state_q == ST_DONE);
  assign verify_err = verr_q;

`ifdef CCFF_CHAIN_LOADER_TAIL_CHECK_EN
  logic [15:0] crc_head;
  logic [15:0] crc_tail;

  assign ccff_shift_en = shift_load || (state_q == ST_VERIFY);
  assign ccff_head     = (state_q == ST_VERIFY) ? ccff_tail
                       : (shift_load ? word_buf[WORD_W-1] : head_q);

  ccff_crc16_serial u_crc_head (
    .clk     (prog_clk),
    .reset_n (prog_reset_n),
    .clr     (restart),
    .en      (shift_load),
    .din     (ccff_head),
    .crc     (crc_head)
  );

  ccff_crc16_serial u_crc_tail (
    .clk     (prog_clk),
    .reset_n (prog_reset_n),
    .clr     (restart),
    .en      (state_q == ST_VERIFY),
    .din     (ccff_tail),
    .crc     (crc_tail)
  );
`else
  logic unused_tail;

  assign unused_tail   = ccff_tail;
  assign ccff_shift_en = shift_load;
  assign ccff_head     = shift_load ? word_buf[WORD_W-1] : head_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
      ST_LOAD:          if (shift_load && last_bit) state_d = TAIL_CHECK ? ST_VERIFY : ST_DONE;
      ST_VERIFY:        if (last_bit) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt   <= '0;
      word_buf  <= '0;
      bits_left <= '0;
      words_acc <= '0;
      head_q    <= 1'b0;
      verr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        bit_cnt   <= '0;
        word_buf  <= '0;
        bits_left <= '0;
        words_acc <= '0;
        verr_q    <= 1'b0;
      end
      if (shift_load) begin
        // The count is reused to time the recirculation pass, so it restarts at the hand-over.
        bit_cnt <= (last_bit && TAIL_CHECK) ? '0 : bit_cnt + 1'b1;
        head_q  <= word_buf[WORD_W-1];
      end
      if (take) begin
        word_buf  <= cfg_word;
        bits_left <= (words_acc == WC_W'(N_WORDS - 1)) ? BL_W'(LAST_BITS) : BL_W'(WORD_W);
        words_acc <= words_acc + 1'b1;
      end else if (shift_load) begin
        word_buf  <= word_buf << 1;
        bits_left <= bits_left - 1'b1;
      end
`ifdef CCFF_CHAIN_LOADER_TAIL_CHECK_EN
      if (state_q == ST_VERIFY) begin
        bit_cnt <= bit_cnt + 1'b1;
        head_q  <= ccff_tail;
        if (last_bit) begin
          verr_q <= (crc_head != crc16_next(crc_tail, ccff_tail));
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed bench for ccff_chain_loader with DFF chain models
module tb_ccff_chain_loader;

`ifdef CCFF_CHAIN_LOADER_TAIL_CHECK_EN
  localparam int VM = 2;
`else
  localparam int VM = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, cfg_valid;
  logic [7:0]  cfg_word;
  logic        a_ready, a_head, a_sh, a_tail, a_busy, a_done, a_verr;
  logic        b_ready, b_head, b_sh, b_tail, b_busy, b_done, b_verr;
  logic [7:0]  chain_a = '0;
  logic [19:0] chain_b = '0;
  logic        flip_a  = 1'b0;
  logic [5:0]  a_o, b_o, o;

  assign a_tail = chain_a[7] ^ flip_a;
  assign b_tail = chain_b[19];
  assign a_o    = {a_ready, a_head, a_sh, a_busy, a_done, a_verr};
  assign b_o    = {b_ready, b_head, b_sh, b_busy, b_done, b_verr};

  always @(posedge clk) begin
    if (a_sh) chain_a <= {chain_a[6:0], a_head};
    if (b_sh) chain_b <= {chain_b[18:0], b_head};
  end

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start), .cfg_word(cfg_word),
    .cfg_valid(cfg_valid), .cfg_ready(a_ready), .ccff_head(a_head), .ccff_shift_en(a_sh),
    .ccff_tail(a_tail), .busy(a_busy), .done(a_done), .verify_err(a_verr));

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start), .cfg_word(cfg_word),
    .cfg_valid(cfg_valid), .cfg_ready(b_ready), .ccff_head(b_head), .ccff_shift_en(b_sh),
    .ccff_tail(b_tail), .busy(b_busy), .done(b_done), .verify_err(b_verr));

  int n_checks = 0, n_pass = 0;
  int tgt = 0, cyc = 0, nsh, first_sh, last_sh, done_cyc;
  logic [63:0] bits;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Outputs sampled on the falling edge describe what the next rising edge will clock.
  task automatic sample();
    cyc++;
    o = (tgt != 0) ? b_o : a_o;
    if (o[3]) begin
      bits = {bits[62:0], o[4]};
      if (nsh == 0) first_sh = cyc;
      last_sh = cyc;
      nsh++;
    end
    if (o[1] && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic next();
    @(negedge clk);
    sample();
  endtask

  function automatic logic [63:0] rep(input logic [63:0] v, input int w);
    rep = (VM == 2) ? ((v << w) | v) : v;
  endfunction

  // evt: 1 = start pulse mid-load, 2 = reset after 3 shifts, 3 = flip one returning tail bit
  task automatic load(input int dut, input int nw, input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] w2, input int stall, input int evt, input int exp_n,
                      input int nb, input logic [63:0] exp_bits, input int exp_gap,
                      input logic [31:0] exp_chain, input logic exp_verr);
    logic [7:0] ws [3];
    int idx, gap, xfer0, extra_rdy;
    logic rdy, xfer;
    bit evdone;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    idx = 0; gap = 0; xfer0 = -1; extra_rdy = 0; evdone = 0;
    tgt = dut; nsh = 0; bits = '0; first_sh = -1; last_sh = -1; done_cyc = -1;
    start = 1'b1;
    next();
    start = 1'b0;
    check("start_busy", o[2], 1'b1);
    check("start_done_clr", o[1], 1'b0);
    check("start_verr_clr", o[0], 1'b0);
    for (int c = 0; c < 300 && !o[1]; c++) begin
      if (evt == 2 && nsh == 4) begin
        rst_n = 1'b0; start = 1'b1; cfg_valid = 1'b0;
        next();
        check("reset_mid_load_outs", o, 6'b0);
        rst_n = 1'b1; start = 1'b0;
        next();
        check("reset_start_ignored", o[2], 1'b0);
        return;
      end
      start = (evt == 1 && nsh == 3 && !evdone);
      if (start) evdone = 1'b1;
      flip_a = (evt == 3 && nsh == 10);
      rdy = o[5];
      cfg_valid = (idx < nw) && (gap == 0);
      cfg_word = ws[(idx > 2) ? 2 : idx];
      xfer = cfg_valid && rdy;
      if (rdy && gap > 0) gap--;
      if (xfer && xfer0 < 0) xfer0 = cyc;
      next();
      if (xfer) begin
        idx++;
        gap = stall;
      end
      if (idx >= nw && o[5]) extra_rdy++;
    end
    start = 1'b0; flip_a = 1'b0; cfg_valid = 1'b0;
    check("done_reached", o[1], 1'b1);
    check("shift_count", nsh, exp_n);
    if (nb > 0) check("shift_bits", bits & ((64'd1 << nb) - 64'd1), exp_bits);
    check("stall_cycles", last_sh - first_sh + 1 - nsh, exp_gap);
    check("done_latency", done_cyc - last_sh, 1);
    check("first_shift_latency", first_sh - xfer0, 1);
    check("ready_after_last_word", extra_rdy, 0);
    check("chain_content", (dut != 0) ? {12'h0, chain_b} : {24'h0, chain_a}, exp_chain);
    check("verify_err", o[0], exp_verr);
  endtask

  task automatic rst();
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    next();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_word = 8'h00;
    next();
    next();
    check("reset_outs_a", a_o, 6'b0);
    check("reset_outs_b", b_o, 6'b0);
    rst_n = 1'b1;
    next();

    load(0, 1, 8'hA5, 8'h00, 8'h00, 0, 0, 8*VM, 8*VM, rep(64'hA5, 8), 0, 32'hA5, 1'b0);

    rst();
    load(1, 3, 8'h12, 8'h34, 8'hF0, 0, 0, 20*VM, 20*VM, rep(64'h1234F, 20), 0, 32'h1234F, 1'b0);

    rst();
    load(1, 3, 8'h12, 8'h34, 8'hF0, 5, 0, 20*VM, 20*VM, rep(64'h1234F, 20), 10, 32'h1234F, 1'b0);

    rst();
    load(0, 1, 8'hA5, 8'h00, 8'h00, 0, 2, 0, 0, 64'h0, 0, 32'h0, 1'b0);
    load(0, 1, 8'h5A, 8'h00, 8'h00, 0, 0, 8*VM, 8*VM, rep(64'h5A, 8), 0, 32'h5A, 1'b0);

    load(0, 1, 8'hC3, 8'h00, 8'h00, 0, 1, 8*VM, 8*VM, rep(64'hC3, 8), 0, 32'hC3, 1'b0);
    load(0, 1, 8'h3C, 8'h00, 8'h00, 0, 0, 8*VM, 8*VM, rep(64'h3C, 8), 0, 32'h3C, 1'b0);

`ifdef CCFF_CHAIN_LOADER_TAIL_CHECK_EN
    load(0, 1, 8'h3C, 8'h00, 8'h00, 0, 3, 16, 0, 64'h0, 0, 32'h7C, 1'b1);
    next();
    next();
    check("verify_err_sticky", a_verr, 1'b1);
    check("done_held", a_done, 1'b1);
    load(0, 1, 8'h3C, 8'h00, 8'h00, 0, 0, 16, 16, 64'h3C3C, 0, 32'h3C, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
